// File: rtl/csr_pkg.sv
// Shared CSR-bus definitions: op and FSM encodings, well-known CSR addresses,
// and the rule for deciding whether an access must write.
package csr_pkg;

  typedef enum logic [1:0] {
    CSR_OP_RSVD = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    PROBE = 2'b01,
    WRITE = 2'b10,
    RESP  = 2'b11
  } csr_state_e;

  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MHARTID = 12'hF14;

  // CSRRW always writes; CSRRS/CSRRC write only when the operand is not suppressed.
  function automatic logic csr_write_req(input csr_op_e op, input logic wsup);
    return (op == CSR_OP_RW) || !wsup;
  endfunction

endpackage

// File: rtl/csr_wmask_gen.sv
// Maps a CSR op and its operand onto the set/clear masks of the CSR bus.
module csr_wmask_gen
  import csr_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  csr_op_e         op_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic [XLEN-1:0] set_o,
  output logic [XLEN-1:0] clear_o
);

  always_comb begin
    set_o   = '0;
    clear_o = '0;
    case (op_i)
      CSR_OP_RW: begin
        set_o   = wdata_i;
        clear_o = ~wdata_i;
      end
      CSR_OP_RS: set_o   = wdata_i;
      CSR_OP_RC: clear_o = wdata_i;
      default: ;
    endcase
  end

endmodule

// File: rtl/csr_access_unit.sv
// CSR-bus initiator: probe (no-op write to elicit ack + old value), optional masked write, respond.
// Define CSR_RO_CHECK_EN to flag writes to read-only CSRs (addr[11:10]==2'b11) here instead of in responders.
module csr_access_unit
  import csr_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 12
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic [1:0]        op_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [XLEN-1:0]   wdata_i,
  input  logic              wsup_i,
  input  logic              flush_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [XLEN-1:0]   rdata_o,
  output logic              illegal_o,
  output logic              csr_en_o,
  output logic [ADDR_W-1:0] csr_addr_o,
  output logic [XLEN-1:0]   csr_set_o,
  output logic [XLEN-1:0]   csr_clear_o,
  input  logic              csr_ack_i,
  input  logic [XLEN-1:0]   csr_rdata_i
);

  csr_state_e        state_q;
  csr_op_e           op_q;
  logic [XLEN-1:0]   wdata_q;
  logic              wsup_q;
  logic              busy_q, done_q, illegal_q, en_q;
  logic [XLEN-1:0]   rdata_q, set_q, clear_q;
  logic [ADDR_W-1:0] addr_q;
  logic [XLEN-1:0]   set_d, clear_d;
  logic              write_req_d, illegal_d;

  csr_wmask_gen #(.XLEN(XLEN)) u_wmask (
    .op_i    (op_q),
    .wdata_i (wdata_q),
    .set_o   (set_d),
    .clear_o (clear_d)
  );

  always_comb begin
    write_req_d = csr_write_req(op_q, wsup_q);
    illegal_d   = !csr_ack_i || (op_q == CSR_OP_RSVD);
`ifdef CSR_RO_CHECK_EN
    if ((addr_q[ADDR_W-1 -: 2] == 2'b11) && write_req_d) illegal_d = 1'b1;
`endif
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      op_q      <= CSR_OP_RSVD;
      wdata_q   <= '0;
      wsup_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      en_q      <= 1'b0;
      rdata_q   <= '0;
      set_q     <= '0;
      clear_q   <= '0;
      addr_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_i && !flush_i) begin
            op_q    <= csr_op_e'(op_i);
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
            wsup_q  <= wsup_i;
            busy_q  <= 1'b1;
            en_q    <= 1'b1;
            state_q <= PROBE;
          end
        end
        PROBE: begin
          if (flush_i) begin
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            rdata_q   <= csr_rdata_i;
            illegal_q <= illegal_d;
            if (!illegal_d && write_req_d) begin
              set_q   <= set_d;
              clear_q <= clear_d;
              state_q <= WRITE;
            end else begin
              en_q    <= 1'b0;
              done_q  <= 1'b1;
              state_q <= RESP;
            end
          end
        end
        WRITE: begin
          en_q    <= 1'b0;
          set_q   <= '0;
          clear_q <= '0;
          if (flush_i) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            done_q  <= 1'b1;
            state_q <= RESP;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // A flush must cut the bus strobe in the same cycle so a responder never commits.
  assign csr_en_o    = en_q & ~flush_i;
  assign csr_addr_o  = addr_q;
  assign csr_set_o   = set_q;
  assign csr_clear_o = clear_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign rdata_o     = rdata_q;
  assign illegal_o   = illegal_q;

endmodule
